semver_cfg_seq: RTL and testbench
=================================

SEMVER_CFG_SEQ -- requirements
Module: semver_cfg_seq

Interface
REQ-001 SHALL have parameter EXP_MAJOR, default 1: required major version.
REQ-002 SHALL have parameter MIN_MINOR, default 2: lowest accepted minor version.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum wait cycles per bus access, 8-bit.
REQ-004 SHALL have port clk_i, in, 1: single clock, all logic rising-edge.
REQ-005 SHALL have port rst_i, in, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port start_i, in, 1: single-cycle pulse that starts a new sequence.
REQ-007 SHALL have port cfg_i, in, 32: configuration word written to the slave's r1 register.
REQ-008 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o, out, 1 each: pipelined Wishbone master controls.
REQ-009 SHALL have ports wb_adr_o, out, [2:2]; wb_sel_o, out, 4; wb_dat_o, out, 32: master address, byte select and write data.
REQ-010 SHALL have ports wb_ack_i, wb_err_i, wb_stall_i, in, 1 each; wb_dat_i, in, 32: slave responses.
REQ-011 SHALL have port busy_o, out, 1: sequence in progress.
REQ-012 SHALL have ports done_o, out, 1 and ok_o, out, 1: sequence finished / finished without error.
REQ-013 SHALL have port err_o, out, 3: error code.
REQ-014 SHALL have port version_o, out, 32: last version word read.

Function
REQ-015 Slave map SHALL be fixed: r1 at adr 0, version at adr 1; version encoding is major [23:16], minor [15:8], patch [7:0].
REQ-016 FSM states SHALL be IDLE, RD_VER, CHECK, WR_CFG, RD_BACK, FIN.
REQ-017 The sequence SHALL start automatically on the first clock after reset deassertion, and on start_i when in IDLE or FIN; start_i SHALL be ignored while busy_o=1.
REQ-018 At start, cfg_i SHALL be latched, and done_o, ok_o and err_o SHALL be cleared.
REQ-019 Sequence: RD_VER reads adr 1 -> CHECK -> WR_CFG writes the latched cfg to adr 0 -> RD_BACK reads adr 0 -> FIN.
REQ-020 Bus cycle: cyc and stb SHALL be raised together, stb held until a cycle with wb_stall_i=0, then dropped; cyc SHALL be held until ack or err, then dropped. There is exactly one transfer per cycle and one idle cycle with cyc=0 between accesses.
REQ-021 wb_sel_o SHALL be 4'hF whenever stb=1.
REQ-022 ack and err in the same cycle SHALL be treated as err.
REQ-023 An 8-bit wait counter SHALL clear at each access start and increment every cycle with cyc=1; reaching TIMEOUT without ack/err SHALL abort with err 2 and drop cyc/stb the next cycle.
REQ-024 CHECK SHALL last one cycle and pass iff major==EXP_MAJOR and minor>=MIN_MINOR (unsigned 8-bit).
REQ-025 Error codes SHALL be: 0 none, 1 bus err, 2 timeout, 3 major mismatch, 4 minor too low, 5 readback differs from cfg.
REQ-026 The first error SHALL end the sequence in FIN with ok_o=0; no further accesses SHALL be issued after an error.
REQ-027 In FIN, done_o=1 and busy_o=0; ok_o=1 iff err_o=0; outputs SHALL hold until the next start.
REQ-028 version_o SHALL update only on a successful RD_VER ack.

Reset
REQ-029 Reset SHALL force IDLE with the pending-autostart flag set; all of cyc, stb, we, busy, done, ok =0; err=0; version_o=0; wb_adr_o=0; wb_dat_o=0; wait counter=0.
REQ-030 Reset mid-access SHALL drop cyc/stb asynchronously; the sequence restarts from RD_VER after reset is released.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the error-code constants, and the address constants ADR_R1=0 and ADR_VER=1.
REQ-032 A sub-module wb_single_access SHALL implement REQ-020 to REQ-023 (req/we/adr/dat in; done/err/timeout/rdata out) and be instantiated once.

Verification
REQ-033 Slave returns version 0x00010203, echoes r1, no stall: one read, one write of cfg_i=0xCAFE0001, one read; done_o=1, ok_o=1, err_o=0, version_o=0x00010203.
REQ-034 Version 0x00020000 -> err_o=3, ok_o=0, and no write cycle observed.
REQ-035 Version 0x00010001 -> err_o=4; version 0x000102FF -> ok_o=1.
REQ-036 Stall held 3 cycles on the write: stb remains high for 4 cycles, exactly one transfer occurs, and the sequence completes ok.
REQ-037 Slave never acks the read-back: err_o=2 after 255 cycles; slave returns r1=0 on read-back -> err_o=5; wb_err_i on RD_VER -> err_o=1.
REQ-038 Reset asserted mid-WR_CFG: cyc drops immediately; after release a full sequence reruns; start_i pulsed while busy has no effect.

Source files
------------

// File: rtl/semver_cfg_seq_pkg.sv
// Shared definitions for the version-check / configure / read-back sequencer:
// FSM states, error codes and the fixed slave register map.
package semver_cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_VER  = 3'd1,
        ST_CHECK   = 3'd2,
        ST_WR_CFG  = 3'd3,
        ST_RD_BACK = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

    typedef logic [2:0] err_code_t;

    localparam err_code_t ERR_NONE     = 3'd0;
    localparam err_code_t ERR_BUS      = 3'd1;
    localparam err_code_t ERR_TIMEOUT  = 3'd2;
    localparam err_code_t ERR_MAJOR    = 3'd3;
    localparam err_code_t ERR_MINOR    = 3'd4;
    localparam err_code_t ERR_READBACK = 3'd5;

    // Slave word addresses (wb_adr_o is bit 2 of the byte address)
    localparam logic ADR_R1  = 1'b0;
    localparam logic ADR_VER = 1'b1;

endpackage

// File: rtl/semver_cfg_seq_wb_single_access.sv
// One pipelined Wishbone access at a time: strobe until accepted, hold the
// cycle until ack/err, or abort once the wait counter reaches TIMEOUT.
module wb_single_access #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic        adr_i,
    input  logic [31:0] dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic        wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    input  logic [31:0] wb_dat_i,
    output logic        done_o,
    output logic        err_o,
    output logic        timeout_o,
    output logic [31:0] rdata_o
);

    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic        adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        resp;
    logic        tmo;

    // A response ends the access; ack together with err counts as err.
    // The timeout fires in the cycle the counter would step onto TIMEOUT,
    // so cyc is low the cycle after the counter reaches it.
    assign resp      = cyc_q & (wb_ack_i | wb_err_i);
    assign tmo       = cyc_q & ~resp & (cnt_q == (TIMEOUT - 8'd1));
    assign done_o    = resp | tmo;
    assign err_o     = cyc_q & wb_err_i;
    assign timeout_o = tmo;
    assign rdata_o   = wb_dat_i;

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = stb_q ? 4'hF : 4'h0;

    // Next-state for the bus handshake and wait counter
    always_comb begin
        cyc_d = cyc_q;
        stb_d = stb_q;
        we_d  = we_q;
        adr_d = adr_q;
        dat_d = dat_q;
        cnt_d = cnt_q;
        if (cyc_q) begin
            cnt_d = cnt_q + 8'd1;
            if (stb_q && !wb_stall_i) begin
                stb_d = 1'b0;
            end
            if (resp || tmo) begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                we_d  = 1'b0;
            end
        end else if (req_i) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            we_d  = we_i;
            adr_d = adr_i;
            dat_d = dat_i;
            cnt_d = 8'd0;
        end
    end

    // Bus state registers; reset drops cyc/stb immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= 1'b0;
            dat_q <= 32'd0;
            cnt_q <= 8'd0;
        end else begin
            cyc_q <= cyc_d;
            stb_q <= stb_d;
            we_q  <= we_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/semver_cfg_seq.sv
// Boot-time configuration sequencer: reads the slave version word, checks
// major/minor compatibility, writes the configuration word to r1 and reads
// it back to confirm. The first error ends the sequence.
module semver_cfg_seq
    import semver_cfg_seq_pkg::*;
#(
    parameter logic [7:0] EXP_MAJOR = 8'd1,
    parameter logic [7:0] MIN_MINOR = 8'd2,
    parameter logic [7:0] TIMEOUT   = 8'd255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] cfg_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [2:2]  wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    input  logic [31:0] wb_dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        ok_o,
    output logic [2:0]  err_o,
    output logic [31:0] version_o
);

    state_t      state_q, state_d;
    logic        pend_q;
    logic        launch_q;
    logic [31:0] cfg_q;
    logic [31:0] version_q;
    err_code_t   err_q, err_d;
    logic        done_q;
    logic        ok_q;
    logic        ver_ld;
    logic        start_seq;

    logic        acc_req;
    logic        acc_we;
    logic        acc_adr;
    logic        acc_done;
    logic        acc_err;
    logic        acc_tmo;
    logic [31:0] acc_rdata;

    // Autostart after reset, or an explicit start once the sequencer is at rest
    assign start_seq = ((state_q == ST_IDLE) && (pend_q || start_i)) ||
                       ((state_q == ST_FIN) && start_i);

    assign done_o    = done_q;
    assign ok_o      = ok_q;
    assign err_o     = err_q;
    assign version_o = version_q;

    wb_single_access #(
        .TIMEOUT(TIMEOUT)
    ) u_acc (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (acc_req),
        .we_i      (acc_we),
        .adr_i     (acc_adr),
        .dat_i     (cfg_q),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_stall_i(wb_stall_i),
        .wb_dat_i  (wb_dat_i),
        .done_o    (acc_done),
        .err_o     (acc_err),
        .timeout_o (acc_tmo),
        .rdata_o   (acc_rdata)
    );

    // Error classification for the current state; first error wins
    always_comb begin
        err_d  = err_q;
        ver_ld = 1'b0;
        case (state_q)
            ST_RD_VER: begin
                if (acc_done) begin
                    if (acc_err)      err_d  = ERR_BUS;
                    else if (acc_tmo) err_d  = ERR_TIMEOUT;
                    else              ver_ld = 1'b1;
                end
            end
            ST_CHECK: begin
                if (version_q[23:16] != EXP_MAJOR)     err_d = ERR_MAJOR;
                else if (version_q[15:8] < MIN_MINOR)  err_d = ERR_MINOR;
            end
            ST_WR_CFG: begin
                if (acc_done) begin
                    if (acc_err)      err_d = ERR_BUS;
                    else if (acc_tmo) err_d = ERR_TIMEOUT;
                end
            end
            ST_RD_BACK: begin
                if (acc_done) begin
                    if (acc_err)                 err_d = ERR_BUS;
                    else if (acc_tmo)            err_d = ERR_TIMEOUT;
                    else if (acc_rdata != cfg_q) err_d = ERR_READBACK;
                end
            end
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: walk the access chain, bail to FIN on any error
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start_seq) state_d = ST_RD_VER;
            end
            ST_RD_VER: begin
                if (acc_done) state_d = (err_d == ERR_NONE) ? ST_CHECK : ST_FIN;
            end
            ST_CHECK: begin
                state_d = (err_d == ERR_NONE) ? ST_WR_CFG : ST_FIN;
            end
            ST_WR_CFG: begin
                if (acc_done) state_d = (err_d == ERR_NONE) ? ST_RD_BACK : ST_FIN;
            end
            ST_RD_BACK: begin
                if (acc_done) state_d = ST_FIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: reads launch one cycle after entering their state (keeps
    // one idle bus cycle), the write launches straight out of a passing CHECK
    always_comb begin
        busy_o  = (state_q != ST_IDLE) && (state_q != ST_FIN);
        acc_req = launch_q || ((state_q == ST_CHECK) && (err_d == ERR_NONE));
        acc_we  = (state_q == ST_CHECK);
        acc_adr = (state_q == ST_RD_VER) ? ADR_VER : ADR_R1;
    end

    // Sequence status, latched configuration and captured version
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q    <= 1'b1;
            launch_q  <= 1'b0;
            cfg_q     <= 32'd0;
            version_q <= 32'd0;
            err_q     <= ERR_NONE;
            done_q    <= 1'b0;
            ok_q      <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            if (start_seq) begin
                cfg_q    <= cfg_i;
                err_q    <= ERR_NONE;
                done_q   <= 1'b0;
                ok_q     <= 1'b0;
                launch_q <= 1'b1;
            end else begin
                launch_q <= (state_q == ST_WR_CFG) && acc_done && (err_d == ERR_NONE);
                err_q    <= err_d;
                if (ver_ld) version_q <= acc_rdata;
                if ((state_q != ST_FIN) && (state_d == ST_FIN)) begin
                    done_q <= 1'b1;
                    ok_q   <= (err_d == ERR_NONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_semver_cfg_seq.sv
// Directed bench for semver_cfg_seq with a small pipelined Wishbone slave
// model whose behaviour (version, stall, missing ack, bad read-back, bus
// error) is set per scenario.
module tb_semver_cfg_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg = 32'hCAFE0001;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [2:2]  wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic        wb_ack_i, wb_err_i, wb_stall_i;
    logic [31:0] wb_dat_i;
    logic        busy, done, ok;
    logic [2:0]  err_code;
    logic [31:0] version;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    semver_cfg_seq dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .cfg_i     (cfg),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_stall_i(wb_stall_i),
        .wb_dat_i  (wb_dat_i),
        .busy_o    (busy),
        .done_o    (done),
        .ok_o      (ok),
        .err_o     (err_code),
        .version_o (version)
    );

    // Slave configuration, set by the scenario tasks
    logic [31:0] sl_version = 32'h00010203;
    logic        sl_noack_rb = 1'b0;
    logic        sl_zero_rb = 1'b0;
    logic        sl_err_ver = 1'b0;
    int          sl_stall_n = 0;

    // Slave state and bus activity counters
    logic [31:0] sl_r1 = 32'd0;
    logic        sl_ack_q = 1'b0;
    logic        sl_err_q = 1'b0;
    logic [31:0] sl_rdat_q = 32'd0;
    int          stall_seen = 0;
    int          n_rd = 0, n_wr = 0, n_cyc = 0, n_wstb = 0, n_selbad = 0;

    assign wb_ack_i   = sl_ack_q;
    assign wb_err_i   = sl_err_q;
    assign wb_dat_i   = sl_rdat_q;
    assign wb_stall_i = wb_stb_o && wb_we_o && (stall_seen < sl_stall_n);

    always @(posedge clk) begin
        sl_ack_q <= 1'b0;
        sl_err_q <= 1'b0;
        if (wb_cyc_o) n_cyc <= n_cyc + 1;
        if (wb_stb_o && wb_we_o) n_wstb <= n_wstb + 1;
        if (wb_stb_o && wb_sel_o != 4'hF) n_selbad <= n_selbad + 1;
        if (!wb_cyc_o) stall_seen <= 0;
        else if (wb_stb_o && wb_stall_i) stall_seen <= stall_seen + 1;
        if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
            if (wb_we_o) begin
                n_wr <= n_wr + 1;
                if (wb_adr_o[2] == 1'b0) sl_r1 <= wb_dat_o;
                sl_ack_q <= 1'b1;
            end else begin
                n_rd <= n_rd + 1;
                if (wb_adr_o[2] == 1'b1) begin
                    sl_rdat_q <= sl_version;
                    if (sl_err_ver) sl_err_q <= 1'b1;
                    else            sl_ack_q <= 1'b1;
                end else begin
                    sl_rdat_q <= sl_zero_rb ? 32'd0 : sl_r1;
                    if (!sl_noack_rb) sl_ack_q <= 1'b1;
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output logic got);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        got = done;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rst_cyc got=%b want=0", wb_cyc_o); end
        checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb got=%b want=0", wb_stb_o); end
        checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got=%b want=0", wb_we_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", done); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL rst_ok got=%b want=0", ok); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL rst_err got=%0d want=0", err_code); end
        checks++; if (version !== 32'd0) begin errors++; $display("FAIL rst_version got=%h want=0", version); end
        checks++; if (wb_adr_o !== 1'b0) begin errors++; $display("FAIL rst_adr got=%b want=0", wb_adr_o); end
        checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL rst_dat got=%h want=0", wb_dat_o); end
        rst = 1'b0;
    endtask

    // Autostart after reset with a compatible slave
    task automatic test_nominal();
        int r0, w0;
        logic got;
        r0 = n_rd; w0 = n_wr;
        wait_done(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL nom_done got=%b want=1", got); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nom_ok got=%b want=1", ok); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL nom_err got=%0d want=0", err_code); end
        checks++; if (version !== 32'h00010203) begin errors++; $display("FAIL nom_version got=%h want=00010203", version); end
        checks++; if (n_rd - r0 !== 2) begin errors++; $display("FAIL nom_reads got=%0d want=2", n_rd - r0); end
        checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL nom_writes got=%0d want=1", n_wr - w0); end
        checks++; if (sl_r1 !== 32'hCAFE0001) begin errors++; $display("FAIL nom_r1 got=%h want=cafe0001", sl_r1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy got=%b want=0", busy); end
        checks++; if (n_selbad !== 0) begin errors++; $display("FAIL nom_sel got=%0d want=0", n_selbad); end
    endtask

    task automatic test_major();
        int r0, w0;
        logic got;
        sl_version = 32'h00020000;
        r0 = n_rd; w0 = n_wr;
        pulse_start();
        wait_done(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL maj_done got=%b want=1", got); end
        checks++; if (err_code !== 3'd3) begin errors++; $display("FAIL maj_err got=%0d want=3", err_code); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL maj_ok got=%b want=0", ok); end
        checks++; if (n_wr - w0 !== 0) begin errors++; $display("FAIL maj_writes got=%0d want=0", n_wr - w0); end
        checks++; if (n_rd - r0 !== 1) begin errors++; $display("FAIL maj_reads got=%0d want=1", n_rd - r0); end
        checks++; if (version !== 32'h00020000) begin errors++; $display("FAIL maj_version got=%h want=00020000", version); end
    endtask

    task automatic test_minor();
        logic got;
        sl_version = 32'h00010001;
        pulse_start();
        wait_done(got);
        checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL min_low_err got=%0d want=4", err_code); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL min_low_ok got=%b want=0", ok); end
        sl_version = 32'h000102FF;
        pulse_start();
        wait_done(got);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL min_edge_ok got=%b want=1", ok); end
        checks++; if (err_code !== 3'd0) begin errors++; $display("FAIL min_edge_err got=%0d want=0", err_code); end
        sl_version = 32'h00010203;
    endtask

    task automatic test_stall();
        int s0, w0;
        logic got;
        cfg = 32'h12345678;
        sl_stall_n = 3;
        s0 = n_wstb; w0 = n_wr;
        pulse_start();
        wait_done(got);
        checks++; if (n_wstb - s0 !== 4) begin errors++; $display("FAIL stall_stb_cycles got=%0d want=4", n_wstb - s0); end
        checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL stall_writes got=%0d want=1", n_wr - w0); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_ok got=%b want=1", ok); end
        checks++; if (sl_r1 !== 32'h12345678) begin errors++; $display("FAIL stall_r1 got=%h want=12345678", sl_r1); end
        sl_stall_n = 0;
    endtask

    // Read-back never acked: 2+2 cycles for the first accesses, 255 waiting
    task automatic test_timeout();
        int c0;
        logic got;
        sl_noack_rb = 1'b1;
        c0 = n_cyc;
        pulse_start();
        wait_done(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_done got=%b want=1", got); end
        checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL tmo_err got=%0d want=2", err_code); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL tmo_ok got=%b want=0", ok); end
        checks++; if (n_cyc - c0 !== 259) begin errors++; $display("FAIL tmo_cyc_cycles got=%0d want=259", n_cyc - c0); end
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL tmo_cyc_low got=%b want=0", wb_cyc_o); end
        sl_noack_rb = 1'b0;
    endtask

    task automatic test_readback();
        logic got;
        sl_zero_rb = 1'b1;
        pulse_start();
        wait_done(got);
        checks++; if (err_code !== 3'd5) begin errors++; $display("FAIL rb_err got=%0d want=5", err_code); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL rb_ok got=%b want=0", ok); end
        sl_zero_rb = 1'b0;
    endtask

    task automatic test_bus_err();
        int w0;
        logic got;
        sl_err_ver = 1'b1;
        w0 = n_wr;
        pulse_start();
        wait_done(got);
        checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL berr_err got=%0d want=1", err_code); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL berr_ok got=%b want=0", ok); end
        checks++; if (version !== 32'h00010203) begin errors++; $display("FAIL berr_version got=%h want=00010203", version); end
        checks++; if (n_wr - w0 !== 0) begin errors++; $display("FAIL berr_writes got=%0d want=0", n_wr - w0); end
        sl_err_ver = 1'b0;
    endtask

    task automatic test_reset_mid();
        int r0, w0;
        logic found;
        logic got;
        found = 1'b0;
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            if (wb_cyc_o && wb_we_o) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_reach_write got=%b want=1", found); end
        rst = 1'b1;
        #1;
        checks++; if (wb_cyc_o !== 1'b0) begin errors++; $display("FAIL mid_cyc_async got=%b want=0", wb_cyc_o); end
        checks++; if (wb_stb_o !== 1'b0) begin errors++; $display("FAIL mid_stb_async got=%b want=0", wb_stb_o); end
        @(negedge clk);
        rst = 1'b0;
        r0 = n_rd; w0 = n_wr;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rerun_busy got=%b want=1", busy); end
        pulse_start();
        wait_done(got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid_done got=%b want=1", got); end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_ok got=%b want=1", ok); end
        checks++; if (n_rd - r0 !== 2) begin errors++; $display("FAIL mid_reads got=%0d want=2", n_rd - r0); end
        checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL mid_writes got=%0d want=1", n_wr - w0); end
        checks++; if (sl_r1 !== 32'h12345678) begin errors++; $display("FAIL mid_r1 got=%h want=12345678", sl_r1); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_major();
        test_minor();
        test_stall();
        test_timeout();
        test_readback();
        test_bus_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
